// File: rtl/cpu_pkg.sv
// Shared types and constants for the operand sequencer slice.
// Widths, FSM states, ALU op and shift codes.
package cpu_pkg;

  localparam int CPU_DW   = 16;
  localparam int CPU_NREG = 8;
  localparam int CPU_AW   = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH_A,
    ST_FETCH_B,
    ST_EXEC,
    ST_WRITE
  } state_e;

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_SUB  = 2'b01;
  localparam logic [1:0] OP_AND  = 2'b10;
  localparam logic [1:0] OP_NOTB = 2'b11;

  localparam logic [1:0] SH_NONE = 2'b00;
  localparam logic [1:0] SH_LSL1 = 2'b01;
  localparam logic [1:0] SH_LSR1 = 2'b10;
  localparam logic [1:0] SH_ASR1 = 2'b11;

endpackage

// File: rtl/regfile.sv
// Register file: one sync write port, async clear,
// a fetch read port and a debug read port.
module regfile
  import cpu_pkg::*;
#(
  parameter int DW   = CPU_DW,
  parameter int NREG = CPU_NREG,
  parameter int AW   = CPU_AW
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata,
  input  logic [AW-1:0] dbg_addr,
  output logic [DW-1:0] dbg_data
);

  logic [DW-1:0] mem_q [NREG];
  logic [DW-1:0] mem_d [NREG];

  // Next array contents: hold, or overwrite one entry.
  always_comb begin
    mem_d = mem_q;
    if (we) mem_d[waddr] = wdata;
  end

  // Storage, cleared on reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NREG; i++)
        mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rdata    = mem_q[raddr];
  assign dbg_data = mem_q[dbg_addr];

endmodule

// File: rtl/alu_operand_sequencer.sv
// Multicycle operand fetch / writeback sequencer in
// front of a combinational 16-bit ALU.
module alu_operand_sequencer
  import cpu_pkg::*;
#(
  parameter int DW   = CPU_DW,
  parameter int NREG = CPU_NREG
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [1:0]         op,
  input  logic [CPU_AW-1:0]  rd,
  input  logic [CPU_AW-1:0]  rn,
  input  logic [CPU_AW-1:0]  rm,
  input  logic [1:0]         shift,
  input  logic               wr_en,
  input  logic [CPU_AW-1:0]  wr_addr,
  input  logic [DW-1:0]      wr_data,
  input  logic [CPU_AW-1:0]  rd_addr,
  output logic [DW-1:0]      rd_data,
  output logic [DW-1:0]      ain,
  output logic [DW-1:0]      bin,
  output logic [1:0]         aluop,
  input  logic [DW-1:0]      alu_out,
  input  logic               alu_z,
  output logic               busy,
  output logic               done,
  output logic               status_z
);

  localparam int AW = CPU_AW;

  state_e        state_q, state_d;
  logic [1:0]    op_q, op_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [AW-1:0] rn_q, rn_d;
  logic [AW-1:0] rm_q, rm_d;
  logic [1:0]    sh_q, sh_d;
  logic [DW-1:0] a_q, a_d;
  logic [DW-1:0] b_q, b_d;
  logic [DW-1:0] c_q, c_d;
  logic          z_q, z_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic          rf_we;
  logic [AW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata;
  logic [AW-1:0] rf_raddr;
  logic [DW-1:0] rf_rdata;
  logic [DW-1:0] b_sh;

  regfile #(
    .DW   (DW),
    .NREG (NREG),
    .AW   (AW)
  ) u_rf (
    .clk      (clk),
    .reset_n  (reset_n),
    .we       (rf_we),
    .waddr    (rf_waddr),
    .wdata    (rf_wdata),
    .raddr    (rf_raddr),
    .rdata    (rf_rdata),
    .dbg_addr (rd_addr),
    .dbg_data (rd_data)
  );

  // Fetch port address and the single write port mux.
  always_comb begin
    rf_raddr = (state_q == ST_FETCH_A) ? rn_q : rm_q;
    rf_we    = 1'b0;
    rf_waddr = wr_addr;
    rf_wdata = wr_data;
    if (state_q == ST_WRITE) begin
      rf_we    = 1'b1;
      rf_waddr = rd_q;
      rf_wdata = c_q;
    end else if (state_q == ST_IDLE) begin
      rf_we    = wr_en;
    end
  end

  // One-bit shifter on the B operand.
  always_comb begin
    b_sh = rf_rdata;
    unique case (sh_q)
      SH_NONE: b_sh = rf_rdata;
      SH_LSL1: b_sh = {rf_rdata[DW-2:0], 1'b0};
      SH_LSR1: b_sh = {1'b0, rf_rdata[DW-1:1]};
      SH_ASR1: b_sh = {rf_rdata[DW-1],
                       rf_rdata[DW-1:1]};
      default: b_sh = rf_rdata;
    endcase
  end

  // Sequencer next state and datapath register updates.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    rd_d    = rd_q;
    rn_d    = rn_q;
    rm_d    = rm_q;
    sh_d    = sh_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    z_d     = z_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          op_d    = op;
          rd_d    = rd;
          rn_d    = rn;
          rm_d    = rm;
          sh_d    = shift;
          state_d = ST_FETCH_A;
          busy_d  = 1'b1;
        end
      end
      ST_FETCH_A: begin
        a_d     = rf_rdata;
        state_d = ST_FETCH_B;
      end
      ST_FETCH_B: begin
        b_d     = b_sh;
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        c_d     = alu_out;
        z_d     = alu_z;
        done_d  = 1'b1;
        state_d = ST_WRITE;
      end
      ST_WRITE: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, latched fields, operands and flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
      rd_q    <= '0;
      rn_q    <= '0;
      rm_q    <= '0;
      sh_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      z_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      rd_q    <= rd_d;
      rn_q    <= rn_d;
      rm_q    <= rm_d;
      sh_q    <= sh_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      z_q     <= z_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign ain      = a_q;
  assign bin      = b_q;
  assign aluop    = op_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign status_z = z_q;

endmodule
